// File: rtl/rr_bus_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
// Holds the state encodings and the rotate-and-priority-encode helper.
package rr_bus_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // First set request scanning last+1, last+2, ... (mod N_REQ); the last owner is scanned last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last + ID_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_8_decoder_3x8.sv
// Enabled 3-to-8 one-hot decoder; all-zero output while disabled.
module decoder_3x8 (
    input  logic       e_i,
    input  logic [2:0] a_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (e_i) y_o[a_i] = 1'b1;
    end

endmodule

// File: rtl/rr_bus_arbiter_8.sv
// Round-robin arbiter for one shared resource among 8 requesters.
// Grant is held until done, requester drop, or hold timeout, followed by a one-cycle gap.
module rr_bus_arbiter_8
    import rr_bus_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    state_t           state_q,   state_d;
    logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
    logic [CNT_W-1:0] hold_q,    hold_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                busy_d = 1'b0;
                if (|req) begin
                    state_d  = ST_OWN;
                    gnt_id_d = rr_pick(req, gnt_id_q);
                    busy_d   = 1'b1;
                end
            end
            ST_OWN: begin
                hold_d = hold_q + 1'b1;
                // done beats abandon beats timeout, so a done on the last cycle never pulses timeout
                if (done || !req[gnt_id_q] || (hold_q == CNT_W'(MAX_HOLD - 1))) begin
                    state_d   = ST_GAP;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    timeout_d = !done && req[gnt_id_q];
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    decoder_3x8 u_dec (
        .e_i (busy_d),
        .a_i (gnt_id_d),
        .y_o (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_id_q  <= ID_W'(N_REQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter_8.sv
// Bench for rr_bus_arbiter_8: cycle model compared every cycle plus directed literal checks.
module tb_rr_bus_arbiter_8;

    localparam int MAX_HOLD = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    rr_bus_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = nobody owns, 1 = granted, 2 = turnaround; held = cycles granted so far.
    int m_phase = 0;
    int m_last  = 7;
    int m_held  = 0;
    bit m_to    = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int nxt;
        if (!rst_n) begin
            m_phase <= 0;
            m_last  <= 7;
            m_held  <= 0;
            m_to    <= 0;
        end else begin
            m_to <= 0;
            if (m_phase == 0) begin
                if (req != 8'h00) begin
                    nxt = -1;
                    for (int k = 1; k <= 8; k++)
                        if (nxt < 0 && req[(m_last + k) % 8]) nxt = (m_last + k) % 8;
                    m_last  <= nxt;
                    m_held  <= 1;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (done || !req[m_last]) m_phase <= 2;
                else if (m_held == MAX_HOLD) begin
                    m_phase <= 2;
                    m_to    <= 1;
                end else m_held <= m_held + 1;
            end else begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", int'(gnt), (m_phase == 1) ? (1 << m_last) : 0);
            check("model_gnt_id", int'(gnt_id), m_last);
            check("model_busy", int'(busy), (m_phase == 1) ? 1 : 0);
            check("model_timeout", int'(timeout), int'(m_to));
            check("inv_onehot0", int'($onehot0(gnt)), 1);
            check("inv_busy_gnt", (gnt != 8'h00) ? 1 : 0, int'(busy));
            if (busy) check("inv_gnt_decode", int'(gnt), 1 << gnt_id);
        end
    end

    task automatic wait_grant(input string name, input logic [7:0] exp, output int zeros);
        bit found;
        found = 0;
        zeros = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (gnt != 8'h00) found = 1;
            else zeros++;
        end
        check(name, int'(gnt), int'(exp));
    endtask

    initial begin : stim
        int z;
        int cnt;
        logic [7:0] rr_exp [3];
        rr_exp[0] = 8'h20;
        rr_exp[1] = 8'h80;
        rr_exp[2] = 8'h04;

        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;

        // Reset state with all requests high, then first grant one clock after release
        check("rst_gnt", int'(gnt), 0);
        check("rst_gnt_id", int'(gnt_id), 7);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", int'(gnt), 8'h01);

        // Round robin among 2, 5, 7 with done after two grant cycles
        req = 8'hA4;
        wait_grant("rr_grant_0", 8'h04, z);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("rr_gap_gnt", int'(gnt), 0);
            wait_grant("rr_grant", rr_exp[g], z);
            check("rr_spacing", z + 1, 2);
        end
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        repeat (3) @(negedge clk);

        // Hold timeout; requester 4 joins mid-grant and must wait
        req = 8'h08;
        wait_grant("to_grant", 8'h08, z);
        req = 8'h18;
        cnt = 1;
        for (int i = 0; i < 40 && gnt == 8'h08; i++) begin
            @(negedge clk);
            if (gnt == 8'h08) cnt++;
        end
        check("to_length", cnt, 15);
        check("to_gap_gnt", int'(gnt), 0);
        check("to_pulse", int'(timeout), 1);
        wait_grant("to_next_owner", 8'h10, z);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Abandon mid-grant: no timeout pulse
        req = 8'h08;
        wait_grant("ab_grant", 8'h08, z);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("ab_gap_gnt", int'(gnt), 0);
        check("ab_no_timeout", int'(timeout), 0);
        repeat (2) @(negedge clk);

        // done on the final permitted cycle wins over timeout
        req = 8'h08;
        wait_grant("dt_grant", 8'h08, z);
        repeat (14) @(negedge clk);
        check("dt_still_owned", int'(gnt), 8'h08);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        check("dt_gap_gnt", int'(gnt), 0);
        check("dt_no_timeout", int'(timeout), 0);
        repeat (3) @(negedge clk);

        // Wrap-around from owner 6
        req = 8'h40;
        wait_grant("wrap_owner6", 8'h40, z);
        req = 8'h41;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_grant("wrap_grant", 8'h01, z);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Asynchronous reset between clock edges while owning
        req = 8'h02;
        wait_grant("ar_grant", 8'h02, z);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_gnt", int'(gnt), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_gnt_id", int'(gnt_id), 7);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant("ar_regrant", 8'h02, z);
        req = 8'h00;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
